focus_search_ctrl: RTL and testbench

Autofocus sequencer for the D8M camera path. It drives the VCM lens through a coarse sweep, then a fine sweep, using the per-frame sharpness sum from the pixel-statistics stage, and parks the lens at the sharpest position. It sits between the sharpness statistics block, which supplies `SUM`/`SUM_VALID`, and the VCM I2C writer, which consumes `VCM_DATA` via `VCM_REQ`/`VCM_ACK`.

---
 rtl/focus_pkg.sv | 28 ++
 rtl/focus_peak_tracker.sv | 40 ++++
 rtl/focus_search_ctrl.sv | 171 +++++++++++++++++
 tb/tb_focus_search_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/focus_pkg.sv
// focus_pkg: shared state encodings, position limit and VCM word packing for the autofocus sequencer.
package focus_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WRITE     = 4'd1,
        S_SETTLE    = 4'd2,
        S_MEASURE   = 4'd3,
        S_EVAL      = 4'd4,
        S_FINE_INIT = 4'd5,
        S_PARK      = 4'd6,
        S_FIN       = 4'd7
    } state_t;

    typedef enum logic [1:0] {
        PH_COARSE = 2'd0,
        PH_FINE   = 2'd1,
        PH_PARK   = 2'd2
    } phase_t;

    localparam int POS_MAX = 1023;

    // DW9714 write word: PD=0, position, slew S=0
    function automatic logic [15:0] vcm_pack(input logic [9:0] pos);
        return {2'b00, pos, 4'b0000};
    endfunction

endpackage

// File: rtl/focus_peak_tracker.sv
// focus_peak_tracker: holds the sharpest sum seen and its lens position.
module focus_peak_tracker #(
    parameter int POS_W = 10,
    parameter int SUM_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic [POS_W-1:0] seed_pos_i,
    input  logic             update_i,
    input  logic [SUM_W-1:0] sum_i,
    input  logic [POS_W-1:0] pos_i,
    output logic [POS_W-1:0] best_pos_o
);

    logic [SUM_W-1:0] best_sum_q, best_sum_d;
    logic [POS_W-1:0] best_pos_q, best_pos_d;
    logic             take;

    // strict compare: a tie keeps the earlier (lower) position
    assign take = update_i && (sum_i > best_sum_q);

    always_comb begin
        best_sum_d = clear_i ? '0 : (take ? sum_i : best_sum_q);
        best_pos_d = clear_i ? seed_pos_i : (take ? pos_i : best_pos_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            best_sum_q <= '0;
            best_pos_q <= '0;
        end else begin
            best_sum_q <= best_sum_d;
            best_pos_q <= best_pos_d;
        end
    end

    assign best_pos_o = best_pos_q;

endmodule

// File: rtl/focus_search_ctrl.sv
// focus_search_ctrl: coarse-then-fine VCM autofocus sweep that parks the lens at the sharpest position.
module focus_search_ctrl
    import focus_pkg::*;
#(
    parameter int POS_W         = 10,
    parameter int COARSE_STEP   = 64,
    parameter int FINE_STEP     = 8,
    parameter int SETTLE_FRAMES = 2,
    parameter int SUM_W         = 32
) (
    input  logic             VIDEO_CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [SUM_W-1:0] SUM,
    input  logic             SUM_VALID,
    input  logic             VCM_ACK,
    output logic             VCM_REQ,
    output logic [15:0]      VCM_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic [POS_W-1:0] BEST_POS,
    output logic [3:0]       STATE
);

    localparam logic [POS_W:0] C_STEP   = (POS_W+1)'(COARSE_STEP);
    localparam logic [POS_W:0] F_STEP   = (POS_W+1)'(FINE_STEP);
    localparam logic [POS_W:0] P_MAX    = (POS_W+1)'(POS_MAX);
    localparam logic [7:0]     SETTLE_N = 8'(SETTLE_FRAMES);

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [POS_W-1:0] pos_q, pos_d, bpos_q, bpos_d, trk_pos, trk_seed, lo;
    logic [POS_W:0]   hi_q, hi_d, c_nxt, f_nxt, hi_nxt, trk_ext;
    logic [7:0]       cnt_q, cnt_d, cnt_inc;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [15:0]      data_q, data_d;
    logic             req_q, req_d, busy_q, busy_d, done_q, done_d;
    logic             trk_clear, trk_update, handshake, settle_done, c_ok, f_ok;

    // positions are extended by one bit so the step adds can never wrap
    assign trk_ext     = {1'b0, trk_pos};
    assign c_nxt       = {1'b0, pos_q} + C_STEP;
    assign f_nxt       = {1'b0, pos_q} + F_STEP;
    assign c_ok        = c_nxt <= P_MAX;
    assign f_ok        = f_nxt <= hi_q;
    assign lo          = (trk_ext >= C_STEP) ? trk_pos - C_STEP[POS_W-1:0] : '0;
    assign hi_nxt      = (trk_ext + C_STEP > P_MAX) ? P_MAX : trk_ext + C_STEP;
    assign handshake   = req_q && VCM_ACK;
    assign cnt_inc     = cnt_q + {7'd0, SUM_VALID};
    assign settle_done = cnt_inc >= SETTLE_N;

    focus_peak_tracker #(
        .POS_W(POS_W),
        .SUM_W(SUM_W)
    ) u_peak (
        .clk_i      (VIDEO_CLK),
        .rst_n_i    (RESET_N),
        .clear_i    (trk_clear),
        .seed_pos_i (trk_seed),
        .update_i   (trk_update),
        .sum_i      (sum_q),
        .pos_i      (pos_q),
        .best_pos_o (trk_pos)
    );

    always_ff @(posedge VIDEO_CLK) begin
        if (!RESET_N)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = START ? S_WRITE : S_IDLE;
            S_WRITE:     state_d = handshake ? ((phase_q == PH_PARK) ? S_FIN : S_SETTLE) : S_WRITE;
            S_SETTLE:    state_d = settle_done ? S_MEASURE : S_SETTLE;
            S_MEASURE:   state_d = SUM_VALID ? S_EVAL : S_MEASURE;
            S_EVAL:      state_d = (phase_q == PH_COARSE) ? (c_ok ? S_WRITE : S_FINE_INIT)
                                                          : (f_ok ? S_WRITE : S_PARK);
            S_FINE_INIT: state_d = S_WRITE;
            S_PARK:      state_d = S_WRITE;
            S_FIN:       state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pos_d      = pos_q;
        phase_d    = phase_q;
        hi_d       = hi_q;
        sum_d      = sum_q;
        trk_clear  = 1'b0;
        trk_seed   = '0;
        trk_update = 1'b0;
        cnt_d      = (state_q == S_SETTLE) ? cnt_inc : '0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    pos_d     = '0;
                    phase_d   = PH_COARSE;
                    trk_clear = 1'b1;
                end
            end
            S_MEASURE: sum_d = SUM_VALID ? SUM : sum_q;
            S_EVAL: begin
                trk_update = 1'b1;
                if (phase_q == PH_COARSE && c_ok)
                    pos_d = c_nxt[POS_W-1:0];
                else if (phase_q == PH_FINE && f_ok)
                    pos_d = f_nxt[POS_W-1:0];
            end
            S_FINE_INIT: begin
                pos_d     = lo;
                hi_d      = hi_nxt;
                phase_d   = PH_FINE;
                trk_clear = 1'b1;
                trk_seed  = trk_pos;
            end
            S_PARK: begin
                pos_d   = trk_pos;
                phase_d = PH_PARK;
            end
            default: ;
        endcase
    end

    // outputs are registered from the next state so REQ/DATA/BUSY/DONE line up with the state they describe
    always_comb begin
        req_d  = state_d == S_WRITE;
        data_d = req_d ? vcm_pack(pos_d) : data_q;
        busy_d = state_d != S_IDLE;
        done_d = state_d == S_FIN;
        bpos_d = done_d ? trk_pos : bpos_q;
    end

    always_ff @(posedge VIDEO_CLK) begin
        if (!RESET_N) begin
            phase_q <= PH_COARSE;
            pos_q   <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bpos_q  <= '0;
        end else begin
            phase_q <= phase_d;
            pos_q   <= pos_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            req_q   <= req_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bpos_q  <= bpos_d;
        end
    end

    assign VCM_REQ  = req_q;
    assign VCM_DATA = data_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign BEST_POS = bpos_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_focus_search_ctrl.sv
// tb_focus_search_ctrl: directed autofocus sweeps against a triangular sharpness model, two builds (settle 2 and 0).
module tb_focus_search_ctrl;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sv = 1'b0, ack = 1'b0, sel = 1'b0;
    logic [31:0] sum = '0;
    logic        req_a, busy_a, done_a, req_b, busy_b, done_b, req, busy, done;
    logic [15:0] data_a, data_b, data;
    logic [9:0]  bpos_a, bpos_b, bpos;
    logic [3:0]  st_a, st_b, st;
    logic        req_p = 1'b0;
    int          checks = 0, errors = 0, writes = 0, pulses_n = 0;

    always #5 clk = ~clk;

    focus_search_ctrl dut_a (
        .VIDEO_CLK(clk), .RESET_N(rst_n), .START(start & ~sel), .SUM(sum),
        .SUM_VALID(sv & ~sel), .VCM_ACK(ack & ~sel), .VCM_REQ(req_a), .VCM_DATA(data_a),
        .BUSY(busy_a), .DONE(done_a), .BEST_POS(bpos_a), .STATE(st_a)
    );

    focus_search_ctrl #(.SETTLE_FRAMES(0)) dut_b (
        .VIDEO_CLK(clk), .RESET_N(rst_n), .START(start & sel), .SUM(sum),
        .SUM_VALID(sv & sel), .VCM_ACK(ack & sel), .VCM_REQ(req_b), .VCM_DATA(data_b),
        .BUSY(busy_b), .DONE(done_b), .BEST_POS(bpos_b), .STATE(st_b)
    );

    assign req  = sel ? req_b  : req_a;
    assign data = sel ? data_b : data_a;
    assign busy = sel ? busy_b : busy_a;
    assign done = sel ? done_b : done_a;
    assign bpos = sel ? bpos_b : bpos_a;
    assign st   = sel ? st_b   : st_a;

    always @(posedge clk) begin
        req_p <= req;
        if (req && !req_p) writes <= writes + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sharp(input int p, input int peak, input int base, input bit flat);
        int d;
        d = (p > peak) ? p - peak : peak - p;
        return flat ? 32'd500 : 32'(base - d * 10);
    endfunction

    task automatic serve(input int p, input bit hold);
        logic [15:0] d0;
        logic [9:0]  pv;
        bit          bad;
        pv = p[9:0];
        for (int i = 0; i < 400 && req !== 1'b1; i++) tick();
        chk("req_seen", {31'd0, req}, 32'd1);
        chk($sformatf("data_pos%0d", p), {16'd0, data}, {16'd0, 2'b00, pv, 4'b0000});
        if (hold) begin
            d0  = data;
            bad = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                sv  = (i % 10 == 5);
                sum = 32'hFFFF_FFFF;
                tick();
                if (req !== 1'b1 || data !== d0) bad = 1'b1;
            end
            sv = 1'b0;
            chk("hold_stable", {31'd0, bad}, 32'd0);
        end
        repeat (2) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("req_drop", {31'd0, req}, 32'd0);
    endtask

    // settle frames carry a huge decoy sum so a miscounted settle corrupts the peak
    task automatic frames(input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) begin
            repeat (3) tick();
            sv  = 1'b1;
            sum = (i == n - 1) ? v : 32'hFFFF_FFF0;
            tick();
            sv = 1'b0;
            pulses_n++;
        end
    endtask

    task automatic run(input int peak, input int base, input bit flat, input int settle,
                       input int lo, input int hi, input int park, input int abort_at,
                       input int hold_at, input int exp_writes, input int exp_pulses);
        int w0, p0, k;
        w0 = writes;
        p0 = pulses_n;
        k  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start", {31'd0, busy}, 32'd1);
        chk("req_start", {31'd0, req}, 32'd1);
        for (int p = 0; p <= 1023; p += 64) begin
            serve(p, p == hold_at);
            if (hold_at >= 0 && p == 256) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("state_settle", {28'd0, st}, 32'd2);
            end
            frames(settle + 1, sharp(p, peak, base, flat));
            if (p == 0) begin
                chk("req_eval", {31'd0, req}, 32'd0);
                tick();
                chk("req_2cyc", {31'd0, req}, 32'd1);
            end
        end
        for (int p = lo; p <= hi; p += 8) begin
            serve(p, 1'b0);
            if (k == abort_at) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                chk("rst_req", {31'd0, req}, 32'd0);
                chk("rst_data", {16'd0, data}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_bpos", {22'd0, bpos}, 32'd0);
                chk("rst_state", {28'd0, st}, 32'd0);
                return;
            end
            k++;
            frames(settle + 1, sharp(p, peak, base, flat));
        end
        serve(park, 1'b0);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("best_pos", {22'd0, bpos}, park);
        chk("state_fin", {28'd0, st}, 32'd7);
        chk("busy_fin", {31'd0, busy}, 32'd1);
        tick();
        chk("done_low", {31'd0, done}, 32'd0);
        chk("busy_low", {31'd0, busy}, 32'd0);
        chk("state_idle", {28'd0, st}, 32'd0);
        chk("write_count", writes - w0, exp_writes);
        chk("pulse_count", pulses_n - p0, exp_pulses);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_req", {31'd0, req}, 32'd0);
        chk("reset_data", {16'd0, data}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_bpos", {22'd0, bpos}, 32'd0);
        chk("reset_state", {28'd0, st}, 32'd0);
        rst_n = 1'b1;
        tick();
        // peak 302: coarse best 320, fine 256..384, park 304
        run(302, 10000, 1'b0, 2, 256, 384, 304, -1, -1, 34, 99);
        // peak 1023 with ACK held off at 512 and a stray START during settle
        run(1023, 20000, 1'b0, 2, 896, 1023, 1016, -1, 512, 33, 96);
        // reset on the third fine point, then restart a flat search from pos 0
        run(302, 10000, 1'b0, 2, 256, 384, 304, 2, -1, 0, 0);
        repeat (2) tick();
        run(0, 0, 1'b1, 2, 0, 64, 0, -1, -1, 26, 75);
        // zero-settle build gives the same answer with one frame per point
        sel = 1'b1;
        repeat (2) tick();
        run(302, 10000, 1'b0, 0, 256, 384, 304, -1, -1, 34, 33);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
